// File: rtl/lcd_hd44780_writer_if.sv
// ----------------------------------------------------------------------------
// lcd_hd44780_writer_if
// Bundles the message-ROM port, the HD44780 parallel bus and the status
// flags of lcd_hd44780_writer.
//   start   : one-cycle request to run init plus message
//   index   : ROM address (4 bits)
//   data_in : ROM word {RS, DB[7:0]}, combinational from index
//   lcd_rs, lcd_rw, lcd_e, lcd_db : panel bus (write only, rw tied 0)
//   busy, done : sequencer status
// modport master : the sequencer side
// modport slave  : the system side (start source, ROM, panel)
// ----------------------------------------------------------------------------
interface lcd_hd44780_writer_if;
  logic       start;
  logic [3:0] index;
  logic [8:0] data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  data_in,
    output index,
    output lcd_rs,
    output lcd_rw,
    output lcd_e,
    output lcd_db,
    output busy,
    output done
  );

  modport slave (
    output start,
    output data_in,
    input  index,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_e,
    input  lcd_db,
    input  busy,
    input  done
  );
endinterface

// File: rtl/lcd_hd44780_writer.sv
// ----------------------------------------------------------------------------
// lcd_hd44780_writer
// Drives a write-only HD44780-compatible character LCD over an 8-bit bus.
// After a power-up delay it waits for start, sends the fixed init sequence
// (0x38, 0x0C, 0x01, 0x06 with RS=0), then streams ROM words {RS,DB} to the
// panel until a 9'h000 terminator or after ROM index 15.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lcd_hd44780_writer_if.master (start, index, data_in, lcd_rs,
//           lcd_rw, lcd_e, lcd_db, busy, done)
// Every write is SETUP (E low, bus stable) -> PULSE (E high) -> WAIT (E low,
// command execution time). ROM words get one extra FETCH cycle in front.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module lcd_hd44780_writer #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int CNT_W          = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  lcd_hd44780_writer_if.master bus
);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_FETCH,
    S_DONE
  } state_t;

  // Counters run 0..N-1, so compare against the last count value.
  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYC - 1);

  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR = 8'h01;  // clear display (slow)
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment, no shift

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CMD_FUNC;
      2'd1:    cmd = CMD_DISP;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       step_reg, step_next;
  logic             init_reg, init_next;   // 1 while sending init commands
  logic [3:0]       index_reg, index_next;
  logic             rs_reg, rs_next;
  logic [7:0]       db_reg, db_next;
  logic             e_reg, e_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] wait_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_POWERUP;
      cnt_reg   <= '0;
      step_reg  <= 2'd0;
      init_reg  <= 1'b0;
      index_reg <= 4'd0;
      rs_reg    <= 1'b0;
      db_reg    <= 8'h00;
      e_reg     <= 1'b0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      step_reg  <= step_next;
      init_reg  <= init_next;
      index_reg <= index_next;
      rs_reg    <= rs_next;
      db_reg    <= db_next;
      e_reg     <= e_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    step_next  = step_reg;
    init_next  = init_reg;
    index_next = index_reg;
    rs_next    = rs_reg;
    db_next    = db_reg;

    // Clear display needs the long wait whether it came from init or ROM.
    wait_last = (!rs_reg && db_reg == CMD_CLEAR) ? CLEAR_LAST : CMD_LAST;

    case (state_reg)
      S_POWERUP: begin
        if (cnt_reg == POWERUP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end

      S_IDLE, S_DONE: begin
        cnt_next = '0;
        if (bus.start) begin
          state_next = S_SETUP;
          index_next = 4'd0;
          step_next  = 2'd0;
          init_next  = 1'b1;
          rs_next    = 1'b0;
          db_next    = CMD_FUNC;
        end
      end

      S_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end
      end

      S_PULSE: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end
      end

      S_WAIT: begin
        if (cnt_reg == wait_last) begin
          cnt_next = '0;
          if (init_reg) begin
            if (step_reg == 2'd3) begin
              init_next  = 1'b0;
              index_next = 4'd0;
              state_next = S_FETCH;
            end else begin
              step_next  = step_reg + 2'd1;
              rs_next    = 1'b0;
              db_next    = init_cmd(step_reg + 2'd1);
              state_next = S_SETUP;
            end
          end else if (index_reg == 4'hF) begin
            // Last ROM slot sent: stop here, index does not wrap.
            state_next = S_DONE;
          end else begin
            index_next = index_reg + 4'd1;
            state_next = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        cnt_next = '0;
        if (bus.data_in == 9'h000) begin
          state_next = S_DONE;
        end else begin
          {rs_next, db_next} = bus.data_in;
          state_next         = S_SETUP;
        end
      end

      default: begin
        state_next = S_POWERUP;
        cnt_next   = '0;
      end
    endcase

    // Status and strobe are decoded from the next state so they leave flops.
    e_next    = (state_next == S_PULSE);
    busy_next = !(state_next == S_IDLE || state_next == S_DONE);
    done_next = (state_next == S_DONE);
  end

  assign bus.index  = index_reg;
  assign bus.lcd_rs = rs_reg;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_e  = e_reg;
  assign bus.lcd_db = db_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule
